// File: rtl/pdata_out_port.sv
// Output-port peripheral: captures processor Pdata writes into a small FWFT FIFO
// and drains them over valid/ready, keeping the most recent accepted write visible.
module pdata_out_port #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       full,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DATA_W-1:0]          last_data,
   output logic                       overflow,
   input  logic                       clr_ovf
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wptr, rptr;
   logic              push, pop, drop;

   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rptr];

   // A pop in the same cycle frees the slot, so a write at full still lands.
   assign pop  = out_valid & out_ready;
   assign push = wr_en & (~full | pop);
   assign drop = wr_en & full & ~pop;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         last_data <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push) begin
            wptr      <= wptr + PW'(1);
            last_data <= wr_data;
         end
         if (pop) rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pdata_out_port.sv
// Directed bench for pdata_out_port with a scoreboard queue of expected drain words.
module tb_pdata_out_port;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en, out_ready, clr_ovf;
   logic [DATA_W-1:0] wr_data;
   logic              full, out_valid, overflow;
   logic [DATA_W-1:0] out_data, last_data;
   logic [$clog2(DEPTH):0] count;

   int nchk  = 0;
   int nfail = 0;

   logic [DATA_W-1:0] q[$];
   int                m_count = 0;
   logic [DATA_W-1:0] m_last  = '0;
   logic              m_ovf   = 1'b0;

   pdata_out_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .last_data(last_data), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("count", 64'(count), 64'(m_count));
      chk("full", 64'(full), 64'(m_count == DEPTH));
      chk("out_valid", 64'(out_valid), 64'(m_count != 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("last_data", 64'(last_data), 64'(m_last));
   endtask

   // One clock cycle: check state left by the previous edge, drive inputs,
   // and predict what the coming edge does.
   task automatic cycle(input logic wr, input logic [DATA_W-1:0] d,
                        input logic rdy, input logic clr);
      logic pop_m, push_m, full_m;
      logic [DATA_W-1:0] e;
      @(negedge clk);
      check_state();
      wr_en = wr; wr_data = d; out_ready = rdy; clr_ovf = clr;
      full_m = (m_count == DEPTH);
      pop_m  = rdy && (m_count != 0);
      push_m = wr && (!full_m || pop_m);
      if (pop_m) begin
         e = q.pop_front();
         chk("drain_data", 64'(out_data), 64'(e));
      end
      if (push_m) begin
         q.push_back(d);
         m_last = d;
      end
      if (wr && full_m && !pop_m) m_ovf = 1'b1;
      else if (clr)               m_ovf = 1'b0;
      m_count = m_count + int'(push_m) - int'(pop_m);
   endtask

   task automatic idle();
      cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      #9;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_last", 64'(last_data), 64'd0);
      #1 rst = 1'b1;

      // Single write, then one-cycle pop.
      cycle(1'b1, 32'h6, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_data", 64'(out_data), 64'd6);
      chk("single_count", 64'(count), 64'd1);
      chk("single_last", 64'(last_data), 64'd6);
      cycle(1'b0, '0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("single_drained_valid", 64'(out_valid), 64'd0);
      chk("single_drained_count", 64'(count), 64'd0);

      // Fill, overflow, drain, clear.
      for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_count", 64'(count), 64'd4);
      cycle(1'b1, 32'h5, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("ovf_set", 64'(overflow), 64'd1);
      chk("ovf_last", 64'(last_data), 64'd4);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("ovf_cleared", 64'(overflow), 64'd0);
      chk("drained_empty", 64'(out_valid), 64'd0);

      // Write at full with simultaneous pop: drain order 2,3,4,9.
      for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
      cycle(1'b1, 32'h9, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("simul_count", 64'(count), 64'd4);
      chk("simul_ovf", 64'(overflow), 64'd0);
      chk("simul_last", 64'(last_data), 64'd9);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Streaming through pointer wrap.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, DATA_W'(32'h10 + i), 1'b1, 1'b0);
         @(posedge clk); #1;
         chk("stream_count_le1", 64'(count <= 1), 64'd1);
         chk("stream_head", 64'(out_data), 64'(32'h10 + i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Asynchronous reset with words queued.
      for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(32'h30 + i), 1'b0, 1'b0);
      idle();
      @(negedge clk);
      wr_en = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_last", 64'(last_data), 64'd0);
      chk("arst_full", 64'(full), 64'd0);
      q.delete(); m_count = 0; m_last = '0; m_ovf = 1'b0;
      @(negedge clk) rst = 1'b1;
      cycle(1'b1, 32'h2A, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("post_rst_head", 64'(out_data), 64'h2A);
      cycle(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Clear/set race: a dropped write beats clr_ovf.
      for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(32'h40 + i), 1'b0, 1'b0);
      cycle(1'b1, 32'h99, 1'b0, 1'b0);
      cycle(1'b1, 32'h98, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("race_ovf", 64'(overflow), 64'd1);
      chk("race_last", 64'(last_data), 64'h44);
      cycle(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      idle();
      @(negedge clk);
      check_state();
      chk("scoreboard_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      nfail++;
      $display("FAIL timeout observed=running expected=finished");
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $fatal(1, "timeout");
   end
endmodule
